// File: rtl/seq_serializer.sv
// seq_serializer: parallel words in over valid/ready, MSB-first serial bit stream out; optional even-parity cycle via SEQ_SERIALIZER_PARITY_EN
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             word_start,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("seq_serializer: WIDTH must be in 2..32");
    end

    state_t           state, n_state;
    logic [WIDTH-1:0] shifter, n_shifter;
    logic [WIDTH-1:0] hold, n_hold;
    logic             hold_full, n_hold_full;
    logic [CW-1:0]    count, n_count;
    logic             n_seq_out;
    logic             take, last;
`ifdef SEQ_SERIALIZER_PARITY_EN
    logic             par, n_par;
`endif

    assign take = in_valid && in_ready;
    assign last = (state == SHIFT) && (count == LAST);

    // next-state decode: load from hold or input at the last bit, otherwise shift and park a new word in hold
    always_comb begin
        n_state     = state;
        n_shifter   = shifter;
        n_hold      = hold;
        n_hold_full = hold_full;
        n_count     = count;
`ifdef SEQ_SERIALIZER_PARITY_EN
        n_par       = par;
`endif
        if (state == IDLE) begin
            if (take) begin
                n_state   = SHIFT;
                n_shifter = in_data;
                n_count   = '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
                n_par     = ^in_data;
`endif
            end
        end else if (last) begin
            n_count = '0;
            if (hold_full) begin
                n_shifter   = hold;
                n_hold_full = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
                n_par       = ^hold;
`endif
            end else if (take) begin
                n_shifter = in_data;
`ifdef SEQ_SERIALIZER_PARITY_EN
                n_par     = ^in_data;
`endif
            end else begin
                n_state = IDLE;
            end
        end else begin
            n_shifter = shifter << 1;
            n_count   = count + CW'(1);
            if (take) begin
                n_hold      = in_data;
                n_hold_full = 1'b1;
            end
        end
`ifdef SEQ_SERIALIZER_PARITY_EN
        n_seq_out = (n_state != SHIFT) ? IDLE_BIT : (n_count == CW'(WIDTH)) ? n_par : n_shifter[WIDTH-1];
`else
        n_seq_out = (n_state == SHIFT) ? n_shifter[WIDTH-1] : IDLE_BIT;
`endif
    end

    // state, datapath and registered outputs; async reset drops any word in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shifter    <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            count      <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par        <= 1'b0;
`endif
            seq_out    <= IDLE_BIT;
            seq_valid  <= 1'b0;
            word_start <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state      <= n_state;
            shifter    <= n_shifter;
            hold       <= n_hold;
            hold_full  <= n_hold_full;
            count      <= n_count;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par        <= n_par;
`endif
            seq_out    <= n_seq_out;
            seq_valid  <= n_state == SHIFT;
            word_start <= n_state == SHIFT && n_count == '0;
            busy       <= n_state == SHIFT || n_hold_full;
            in_ready   <= !n_hold_full;
        end
    end
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed vector table plus reset and detector-hookup sequences for seq_serializer
module tb_seq_serializer;
    typedef struct {
        logic [3:0] data;
        logic       valid;
        logic       so, sv, ws, rdy, bz;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_data4 = '0;
    logic       in_valid4 = 1'b0;
    logic       in_ready4, seq_out4, seq_valid4, word_start4, busy4;
    logic [7:0] in_data8 = '0;
    logic       in_valid8 = 1'b0;
    logic       in_ready8, seq_out8, seq_valid8, word_start8, busy8;
    logic [2:0] det_st;
    logic       detect_out;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[$];

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(4), .IDLE_BIT(1'b0)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .seq_out(seq_out4), .seq_valid(seq_valid4), .word_start(word_start4), .busy(busy4)
    );

    seq_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .seq_out(seq_out8), .seq_valid(seq_valid8), .word_start(word_start8), .busy(busy8)
    );

    // reference 1011 overlapping sequence detector with registered detect_out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_st     <= 3'd0;
            detect_out <= 1'b0;
        end else begin
            detect_out <= det_st == 3'd4;
            det_st <= (det_st == 3'd2) ? (seq_out8 ? 3'd3 : 3'd0) :
                      (det_st == 3'd3) ? (seq_out8 ? 3'd4 : 3'd2) :
                      (det_st == 3'd0) ? (seq_out8 ? 3'd1 : 3'd0) :
                      (seq_out8 ? 3'd1 : 3'd2);
        end
    end

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] d, input logic v, input logic so, input logic sv,
                       input logic ws, input logic rdy, input logic bz);
        vec_t r;
        r.data = d; r.valid = v; r.so = so; r.sv = sv; r.ws = ws; r.rdy = rdy; r.bz = bz;
        tbl.push_back(r);
    endtask

    task automatic chk_idle4(input string tag, input int idx);
        chk({tag, "_seq_out"}, idx, seq_out4, 1'b0);
        chk({tag, "_seq_valid"}, idx, seq_valid4, 1'b0);
        chk({tag, "_word_start"}, idx, word_start4, 1'b0);
        chk({tag, "_in_ready"}, idx, in_ready4, 1'b1);
        chk({tag, "_busy"}, idx, busy4, 1'b0);
    endtask

    initial begin
        int pulses;
        int pulse_at;
`ifdef SEQ_SERIALIZER_PARITY_EN
        add(4'b1011, 1, 1, 1, 1, 1, 1);
        add(4'b0000, 0, 0, 1, 0, 1, 1);
        add(4'b0000, 0, 1, 1, 0, 1, 1);
        add(4'b0000, 0, 1, 1, 0, 1, 1);
        add(4'b0000, 0, 1, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 0, 0, 1, 0);
        add(4'b1011, 1, 1, 1, 1, 1, 1);
        add(4'b0110, 1, 0, 1, 0, 0, 1);
        add(4'b1100, 1, 1, 1, 0, 0, 1);
        add(4'b1100, 1, 1, 1, 0, 0, 1);
        add(4'b1100, 1, 1, 1, 0, 0, 1);
        add(4'b1100, 1, 0, 1, 1, 1, 1);
        add(4'b1100, 1, 1, 1, 0, 0, 1);
        add(4'b0000, 0, 1, 1, 0, 0, 1);
        add(4'b0000, 0, 0, 1, 0, 0, 1);
        add(4'b0000, 0, 0, 1, 0, 0, 1);
        add(4'b0000, 0, 1, 1, 1, 1, 1);
        add(4'b0000, 0, 1, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 0, 0, 1, 0);
`else
        add(4'b1011, 1, 1, 1, 1, 1, 1);
        add(4'b0000, 0, 0, 1, 0, 1, 1);
        add(4'b0000, 0, 1, 1, 0, 1, 1);
        add(4'b0000, 0, 1, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 0, 0, 1, 0);
        add(4'b1011, 1, 1, 1, 1, 1, 1);
        add(4'b0110, 1, 0, 1, 0, 0, 1);
        add(4'b1100, 1, 1, 1, 0, 0, 1);
        add(4'b1100, 1, 1, 1, 0, 0, 1);
        add(4'b1100, 1, 0, 1, 1, 1, 1);
        add(4'b1100, 1, 1, 1, 0, 0, 1);
        add(4'b0000, 0, 1, 1, 0, 0, 1);
        add(4'b0000, 0, 0, 1, 0, 0, 1);
        add(4'b0000, 0, 1, 1, 1, 1, 1);
        add(4'b0000, 0, 1, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 0, 0, 1, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_idle4("reset", 0);
        chk("reset_det", 0, detect_out, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        in_data4 = 4'b1011;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_seq_valid", 1, seq_valid4, 1'b1);
        @(negedge clk);
        in_valid4 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", 2, busy4, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle4("async", 3);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle4("no_replay", 4);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in_data4 = tbl[i].data;
            in_valid4 = tbl[i].valid;
            @(posedge clk);
            #1;
            chk("seq_out", i, seq_out4, tbl[i].so);
            chk("seq_valid", i, seq_valid4, tbl[i].sv);
            chk("word_start", i, word_start4, tbl[i].ws);
            chk("in_ready", i, in_ready4, tbl[i].rdy);
            chk("busy", i, busy4, tbl[i].bz);
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        in_data8 = 8'b1011_0000;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        chk("det_first_bit", 1, seq_out8, 1'b1);
        chk("det_word_start", 1, word_start8, 1'b1);
        pulses = 0;
        pulse_at = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (detect_out) begin
                pulses++;
                pulse_at = k;
            end
        end
        chk("det_one_pulse", 0, pulses == 1, 1'b1);
        chk("det_pulse_cycle", pulse_at, pulse_at == 6, 1'b1);
        chk("det_idle_after", 14, seq_valid8, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
